// File: rtl/aq_spsram_init_wrap.sv
// Single-port SRAM with per-bit write mask, a registered read port and a
// hardware sweep that writes INIT_VALUE to every word after reset or on request.
module aq_spsram_init_wrap #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  input  logic                  INIT_REQ,
  output logic                  INIT_BUSY,
  output logic                  INIT_DONE,
  output logic                  ACC_DROP
);

  localparam int                    DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = '1;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; clearing it is the sweep's
  // job, and a reset port on every word would stop it mapping onto a macro.
  always_ff @(posedge CLK) begin
    if (cpurst_b) begin
      if (state == ST_INIT) begin
        mem[cnt] <= INIT_VALUE;
      end else if (!CEN && !GWEN) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
      end
    end
  end

  // NOTE: every register here takes <= so all of them see the pre-edge values,
  // including mem[A] read back for Q in the same edge as a write elsewhere.
  always_ff @(posedge CLK) begin
    if (!cpurst_b) begin
      state     <= ST_INIT;
      cnt       <= '0;
      INIT_BUSY <= 1'b1;
      INIT_DONE <= 1'b0;
      ACC_DROP  <= 1'b0;
      Q         <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          ACC_DROP <= !CEN;
          if (cnt == LAST_ADR) begin
            state     <= ST_READY;
            cnt       <= '0;
            INIT_BUSY <= 1'b0;
            INIT_DONE <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          ACC_DROP <= 1'b0;
          if (!CEN && GWEN) begin
            Q <= mem[A];
          end
          // The access above still completes; the request only redirects the FSM.
          if (INIT_REQ) begin
            state     <= ST_INIT;
            cnt       <= '0;
            INIT_BUSY <= 1'b1;
            INIT_DONE <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aq_spsram_init_wrap.sv
// Scoreboard bench: stimulus pushes expected read/drop responses, a monitor
// pops and compares them when the DUTs present read data or an ACC_DROP pulse.
module tb_aq_spsram_init_wrap;

  logic       CLK = 1'b0;
  logic       cpurst_b;
  logic [6:0] A;
  logic       CEN, GWEN, INIT_REQ;
  logic [7:0] WEN, D;
  logic [7:0] Q, Q2;
  logic       INIT_BUSY, INIT_DONE, ACC_DROP;
  logic       INIT_BUSY2, INIT_DONE2, ACC_DROP2;

  int checks   = 0;
  int failures = 0;

  // Expected entries: {exp for default DUT, exp for 0xA5 DUT}
  string       rd_name_q[$];
  logic [15:0] rd_exp_q[$];
  string       dr_name_q[$];
  logic [15:0] dr_exp_q[$];
  logic        mark_rd = 1'b0;
  logic        rd_seen = 1'b0;

  always #5 CLK = ~CLK;

  aq_spsram_init_wrap u_dut (
    .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .D(D), .Q(Q), .INIT_REQ(INIT_REQ), .INIT_BUSY(INIT_BUSY),
    .INIT_DONE(INIT_DONE), .ACC_DROP(ACC_DROP)
  );

  aq_spsram_init_wrap #(.INIT_VALUE(8'hA5)) u_dut_a5 (
    .CLK(CLK), .cpurst_b(cpurst_b), .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN),
    .D(D), .Q(Q2), .INIT_REQ(INIT_REQ), .INIT_BUSY(INIT_BUSY2),
    .INIT_DONE(INIT_DONE2), .ACC_DROP(ACC_DROP2)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: read data appears the cycle after a read edge; drops whenever pulsed.
  always @(posedge CLK) rd_seen <= mark_rd;

  always @(negedge CLK) begin
    if (rd_seen) begin
      if (rd_exp_q.size() == 0) begin
        check("read_unexpected", 1, 0);
      end else begin
        string       nm;
        logic [15:0] e;
        nm = rd_name_q.pop_front();
        e  = rd_exp_q.pop_front();
        check({nm, "_q"}, {24'd0, Q}, {24'd0, e[15:8]});
        check({nm, "_q_a5"}, {24'd0, Q2}, {24'd0, e[7:0]});
      end
    end
    if (ACC_DROP === 1'b1 || ACC_DROP2 === 1'b1) begin
      if (dr_exp_q.size() == 0) begin
        check("acc_drop_unexpected", 1, 0);
      end else begin
        string       nm;
        logic [15:0] e;
        nm = dr_name_q.pop_front();
        e  = dr_exp_q.pop_front();
        check({nm, "_drop"}, {30'd0, ACC_DROP, ACC_DROP2}, 32'd3);
        check({nm, "_q_held"}, {16'd0, Q, Q2}, {16'd0, e});
      end
    end
  end

  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_read(input string name, input logic [6:0] a, input logic [15:0] exp);
    A = a; CEN = 1'b0; GWEN = 1'b1;
    rd_name_q.push_back(name);
    rd_exp_q.push_back(exp);
    mark_rd = 1'b1;
    cycle();
    CEN = 1'b1; mark_rd = 1'b0;
  endtask

  // A read issued while busy: a drop pulse is expected with Q unchanged.
  task automatic do_drop_read(input string name, input logic [6:0] a, input logic [15:0] q_now);
    A = a; CEN = 1'b0; GWEN = 1'b1;
    dr_name_q.push_back(name);
    dr_exp_q.push_back(q_now);
    cycle();
    CEN = 1'b1;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input logic [7:0] wen);
    A = a; D = d; WEN = wen; CEN = 1'b0; GWEN = 1'b0;
    cycle();
    CEN = 1'b1; GWEN = 1'b1; WEN = '1;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n = 0;
    while ((INIT_BUSY || INIT_BUSY2) && n < 400) begin
      cycle();
      n++;
    end
    check({name, "_busy_cycles"}, n, exp_cycles);
    check({name, "_done"}, {30'd0, INIT_DONE, INIT_DONE2}, 32'd3);
    check({name, "_busy_low"}, {30'd0, INIT_BUSY, INIT_BUSY2}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cpurst_b = 1'b0; A = '0; CEN = 1'b1; GWEN = 1'b1; WEN = '1; D = '0; INIT_REQ = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_busy", {30'd0, INIT_BUSY, INIT_BUSY2}, 32'd3);
    check("reset_done", {30'd0, INIT_DONE, INIT_DONE2}, 32'd0);
    check("reset_drop", {30'd0, ACC_DROP, ACC_DROP2}, 32'd0);
    check("reset_q", {16'd0, Q, Q2}, 32'd0);
    cpurst_b = 1'b1;
    wait_ready("first_sweep", 128);

    do_read("init_rd0", 7'd0, 16'h00A5);
    do_read("init_rd63", 7'd63, 16'h00A5);
    do_read("init_rd127", 7'd127, 16'h00A5);

    // Masked writes: A5 & 0F | F0 = F5; then bit0 cleared -> F4.
    do_write(7'd5, 8'hFF, 8'h0F);
    do_read("mask_rd1", 7'd5, 16'hF0F5);
    do_write(7'd5, 8'h00, 8'hFE);
    do_read("mask_rd2", 7'd5, 16'hF0F4);

    // Q hold through a write and idle cycles.
    do_read("hold_rd5", 7'd5, 16'hF0F4);
    do_write(7'd6, 8'h3C, 8'h00);
    check("hold_after_wr", {16'd0, Q, Q2}, 32'h0000F0F4);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_idle", {16'd0, Q, Q2}, 32'h0000F0F4);
    end
    do_read("hold_rd6", 7'd6, 16'h3C3C);

    // Re-init together with a write to A=2; the write lands, then gets swept.
    A = 7'd2; D = 8'h55; WEN = 8'h00; CEN = 1'b0; GWEN = 1'b0; INIT_REQ = 1'b1;
    cycle();
    CEN = 1'b1; GWEN = 1'b1; WEN = '1; INIT_REQ = 1'b0;
    check("reinit_busy", {30'd0, INIT_BUSY, INIT_BUSY2}, 32'd3);
    check("reinit_done", {30'd0, INIT_DONE, INIT_DONE2}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      do_drop_read("busy_rd", 7'd6, 16'h3C3C);
      cycle();
    end
    wait_ready("reinit", 122);
    check("drops_all_seen", dr_exp_q.size(), 0);
    do_read("reinit_rd2", 7'd2, 16'h00A5);

    // Reset in the middle of a sweep restarts it from word 0.
    INIT_REQ = 1'b1;
    cycle();
    INIT_REQ = 1'b0;
    repeat (39) cycle();
    cpurst_b = 1'b0;
    cycle();
    cpurst_b = 1'b1;
    check("midrst_q", {16'd0, Q, Q2}, 32'd0);
    check("midrst_busy", {30'd0, INIT_BUSY, INIT_BUSY2}, 32'd3);
    check("midrst_done", {30'd0, INIT_DONE, INIT_DONE2}, 32'd0);
    wait_ready("midrst", 128);

    // A request during the sweep must not extend it.
    INIT_REQ = 1'b1;
    cycle();
    INIT_REQ = 1'b0;
    repeat (99) cycle();
    INIT_REQ = 1'b1;
    cycle();
    INIT_REQ = 1'b0;
    wait_ready("req_in_init", 28);
    do_read("final_rd2", 7'd2, 16'h00A5);

    cycle();
    check("reads_all_seen", rd_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
